// File: rtl/perf_counter_pkg.sv
// Shared constants and types for the writeback-side performance counters.
// Holds the counter map and the helper that builds the per-cycle event vector.
package perf_counter_pkg;

    localparam int PERF_NUM   = 8;
    localparam int PERF_IDX_W = 3;

    typedef enum logic [PERF_IDX_W-1:0] {
        PERF_CYCLE  = 3'd0,
        PERF_INST   = 3'd1,
        PERF_BR     = 3'd2,
        PERF_BRPRE  = 3'd3,
        PERF_BRERR  = 3'd4,
        PERF_MEM    = 3'd5,
        PERF_ICMISS = 3'd6,
        PERF_DCMISS = 3'd7
    } perf_idx_t;

    typedef struct packed {
        logic dcache_miss;
        logic icache_miss;
        logic mem_inst;
        logic br_pre_error;
        logic br_pre;
        logic br_inst;
        logic valid;
    } wb_ev_t;

    // Bit 0 is the cycle event; the whole vector is gated by the enable.
    function automatic logic [PERF_NUM-1:0] ev_vec(input wb_ev_t ev, input logic en);
        return {ev, 1'b1} & {PERF_NUM{en}};
    endfunction

endpackage

// File: rtl/perf_cnt_slice.sv
// One wide event counter with synchronous clear and sticky wrap flag.
// Clear beats both the increment and the overflow set.
module perf_cnt_slice
    import perf_counter_pkg::*;
#(
    parameter int CNT_WD = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ev,
    input  logic              clr,
    input  logic              ovf_clr,
    output logic [CNT_WD-1:0] cnt,
    output logic              ovf
);

    logic wrap;

    assign wrap = ev & (&cnt);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt + {{(CNT_WD-1){1'b0}}, ev};
            // A wrap in the same cycle as a software clear keeps the flag.
            ovf <= wrap | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: rtl/perf_counter.sv
// Writeback-side performance counters: sample stage, eight counter slices,
// and a one-cycle read port with a high-word shadow for 64-bit snapshots.
module perf_counter
    import perf_counter_pkg::*;
#(
    parameter int CNT_WD = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  real_valid,
    input  logic                  real_br_inst,
    input  logic                  real_br_pre,
    input  logic                  real_br_pre_error,
    input  logic                  real_mem_inst,
    input  logic                  real_icache_miss,
    input  logic                  real_dcache_miss,
    input  logic                  cnt_en,
    input  logic                  cnt_clr,
    input  logic [PERF_NUM-1:0]   ovf_clr,
    input  logic                  rd_req,
    input  logic [PERF_IDX_W-1:0] rd_idx,
    input  logic                  rd_hi,
    output logic                  rd_ack,
    output logic [31:0]           rd_data,
    output logic [PERF_NUM-1:0]   ovf_flag,
    output logic                  ovf_irq
);

    wb_ev_t              wb_ev;
    logic [PERF_NUM-1:0] ev_r;
    logic [CNT_WD-1:0]   cnt [PERF_NUM];
    logic [CNT_WD-1:0]   sel;
    logic [63:0]         sel_ext;
    logic [31:0]         shadow_hi;

    assign wb_ev = '{
        dcache_miss:  real_dcache_miss,
        icache_miss:  real_icache_miss,
        mem_inst:     real_mem_inst,
        br_pre_error: real_br_pre_error,
        br_pre:       real_br_pre,
        br_inst:      real_br_inst,
        valid:        real_valid
    };

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ev_r <= '0;
        end else if (cnt_clr) begin
            ev_r <= '0;
        end else begin
            ev_r <= ev_vec(wb_ev, cnt_en);
        end
    end

    for (genvar i = 0; i < PERF_NUM; i++) begin : g_slice
        perf_cnt_slice #(
            .CNT_WD (CNT_WD)
        ) u_slice (
            .clk     (clk),
            .resetn  (resetn),
            .ev      (ev_r[i]),
            .clr     (cnt_clr),
            .ovf_clr (ovf_clr[i]),
            .cnt     (cnt[i]),
            .ovf     (ovf_flag[i])
        );
    end

    assign sel     = cnt[rd_idx];
    assign sel_ext = 64'(sel);
    assign ovf_irq = |ovf_flag;

    // The high half is latched on the low read so lo/hi pairs are coherent.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ack    <= 1'b0;
            rd_data   <= '0;
            shadow_hi <= '0;
        end else if (rd_req) begin
            rd_ack <= 1'b1;
            if (rd_hi) begin
                rd_data <= shadow_hi;
            end else begin
                rd_data   <= sel_ext[31:0];
                shadow_hi <= sel_ext[63:32];
            end
        end else begin
            rd_ack <= 1'b0;
        end
    end

endmodule

// File: tb/tb_perf_counter.sv
// Directed bench for perf_counter: counting, reads, shadow, wrap and clear.
// Expected values are worked out by hand from the cycle timeline.
module tb_perf_counter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        real_valid, real_br_inst, real_br_pre, real_br_pre_error;
    logic        real_mem_inst, real_icache_miss, real_dcache_miss;
    logic        cnt_en, cnt_clr;
    logic [7:0]  ovf_clr;
    logic        rd_req;
    logic [2:0]  rd_idx;
    logic        rd_hi;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic [7:0]  ovf_flag;
    logic        ovf_irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] d;
    logic        a;

    always #5 clk = ~clk;

    perf_counter #(.CNT_WD(64)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .real_valid        (real_valid),
        .real_br_inst      (real_br_inst),
        .real_br_pre       (real_br_pre),
        .real_br_pre_error (real_br_pre_error),
        .real_mem_inst     (real_mem_inst),
        .real_icache_miss  (real_icache_miss),
        .real_dcache_miss  (real_dcache_miss),
        .cnt_en            (cnt_en),
        .cnt_clr           (cnt_clr),
        .ovf_clr           (ovf_clr),
        .rd_req            (rd_req),
        .rd_idx            (rd_idx),
        .rd_hi             (rd_hi),
        .rd_ack            (rd_ack),
        .rd_data           (rd_data),
        .ovf_flag          (ovf_flag),
        .ovf_irq           (ovf_irq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] idx, input logic hi,
                      output logic [31:0] data, output logic ack);
        rd_req = 1'b1;
        rd_idx = idx;
        rd_hi  = hi;
        step();
        data   = rd_data;
        ack    = rd_ack;
        rd_req = 1'b0;
    endtask

    task automatic set_ev(input logic v);
        real_valid        = v;
        real_br_inst      = v;
        real_br_pre       = v;
        real_br_pre_error = v;
        real_mem_inst     = v;
        real_icache_miss  = v;
        real_dcache_miss  = v;
    endtask

    initial begin
        resetn  = 1'b0;
        set_ev(1'b0);
        cnt_en  = 1'b1;
        cnt_clr = 1'b0;
        ovf_clr = '0;
        rd_req  = 1'b0;
        rd_idx  = '0;
        rd_hi   = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_ack", 64'(rd_ack), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_ovf", 64'(ovf_flag), 64'd0);
        chk("rst_irq", 64'(ovf_irq), 64'd0);
        resetn = 1'b1;

        // Cycle counter: 10 idle cycles then read idx 0
        repeat (10) step();
        rd(3'd0, 1'b0, d, a);
        chk("cyc_ack", 64'(a), 64'd1);
        chk("cyc_val", 64'(d), 64'd9);
        step();
        chk("cyc_ack_drop", 64'(rd_ack), 64'd0);
        chk("cyc_data_hold", 64'(rd_data), 64'd9);

        // Retire and mispredict events
        cnt_clr = 1'b1;
        step();
        cnt_clr           = 1'b0;
        real_valid        = 1'b1;
        real_br_pre_error = 1'b1;
        repeat (2) step();
        real_br_pre_error = 1'b0;
        repeat (3) step();
        real_valid = 1'b0;
        repeat (2) step();
        rd(3'd1, 1'b0, d, a);
        chk("inst_cnt", 64'(d), 64'd5);
        rd(3'd4, 1'b0, d, a);
        chk("brerr_cnt", 64'(d), 64'd2);
        rd(3'd2, 1'b0, d, a);
        chk("br_zero", 64'(d), 64'd0);
        rd(3'd3, 1'b0, d, a);
        chk("brpre_zero", 64'(d), 64'd0);
        rd(3'd5, 1'b0, d, a);
        chk("mem_zero", 64'(d), 64'd0);
        rd(3'd6, 1'b0, d, a);
        chk("icm_zero", 64'(d), 64'd0);
        rd(3'd7, 1'b0, d, a);
        chk("dcm_zero", 64'(d), 64'd0);

        // Wrap of counter 6
        force dut.g_slice[6].u_slice.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        release dut.g_slice[6].u_slice.cnt;
        real_icache_miss = 1'b1;
        step();
        real_icache_miss = 1'b0;
        step();
        chk("wrap_flag", 64'(ovf_flag), 64'h40);
        chk("wrap_irq", 64'(ovf_irq), 64'd1);
        rd(3'd6, 1'b0, d, a);
        chk("wrap_cnt", 64'(d), 64'd0);

        // Second wrap coincident with ovf_clr: set wins
        force dut.g_slice[6].u_slice.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        release dut.g_slice[6].u_slice.cnt;
        real_icache_miss = 1'b1;
        step();
        real_icache_miss = 1'b0;
        ovf_clr          = 8'h40;
        step();
        ovf_clr = '0;
        chk("set_wins", 64'(ovf_flag), 64'h40);
        ovf_clr = 8'h40;
        step();
        ovf_clr = '0;
        chk("w1c_flag", 64'(ovf_flag), 64'h00);
        chk("w1c_irq", 64'(ovf_irq), 64'd0);

        // Lo/hi snapshot while branches keep counting
        real_br_inst = 1'b1;
        repeat (2) step();
        force dut.g_slice[2].u_slice.cnt = 64'h0000_0001_FFFF_FFFF;
        release dut.g_slice[2].u_slice.cnt;
        rd(3'd2, 1'b0, d, a);
        chk("snap_lo", 64'(d), 64'hFFFF_FFFF);
        rd(3'd5, 1'b1, d, a);
        chk("snap_hi", 64'(d), 64'h1);
        rd(3'd2, 1'b0, d, a);
        chk("live_lo", 64'(d), 64'h1);
        rd(3'd0, 1'b1, d, a);
        chk("live_hi", 64'(d), 64'h2);
        real_br_inst = 1'b0;

        // Leave a flag set so the clear below has something to drop
        force dut.g_slice[7].u_slice.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        release dut.g_slice[7].u_slice.cnt;
        real_dcache_miss = 1'b1;
        step();
        real_dcache_miss = 1'b0;
        step();
        chk("dcm_wrap_flag", 64'(ovf_flag), 64'h80);

        // Clear coincident with an event and a read
        cnt_clr = 1'b1;
        step();
        cnt_clr       = 1'b0;
        real_mem_inst = 1'b1;
        repeat (7) step();
        real_mem_inst = 1'b0;
        repeat (2) step();
        cnt_clr       = 1'b1;
        real_mem_inst = 1'b1;
        rd(3'd5, 1'b0, d, a);
        cnt_clr       = 1'b0;
        real_mem_inst = 1'b0;
        chk("clr_read_old", 64'(d), 64'd7);
        chk("clr_flags", 64'(ovf_flag), 64'h00);
        chk("clr_irq", 64'(ovf_irq), 64'd0);
        repeat (2) step();
        rd(3'd5, 1'b0, d, a);
        chk("clr_dropped", 64'(d), 64'd0);

        // Count-enable gap of 4 cycles under continuous events
        cnt_clr = 1'b1;
        set_ev(1'b1);
        step();
        cnt_clr = 1'b0;
        repeat (3) step();
        cnt_en = 1'b0;
        repeat (4) step();
        cnt_en = 1'b1;
        repeat (5) step();
        cnt_en = 1'b0;
        repeat (2) step();
        set_ev(1'b0);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), 1'b0, d, a);
            chk($sformatf("en_gap_%0d", i), 64'(d), 64'd8);
        end

        // Reset during a read drops the ack at once
        rd_req = 1'b1;
        rd_idx = 3'd0;
        rd_hi  = 1'b0;
        step();
        rd_req = 1'b0;
        chk("pre_rst_ack", 64'(rd_ack), 64'd1);
        resetn = 1'b0;
        #1;
        chk("async_rst_ack", 64'(rd_ack), 64'd0);
        chk("async_rst_data", 64'(rd_data), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
